// File: rtl/piece_bag_queue.sv
// piece_bag_queue: 7-bag filter in front of a shallow preview FIFO.
// Raw shape codes 1..7 are accepted only if not yet drawn in the current bag.
// A long run of rejections forces the lowest missing code in.
// Entry 0 of the FIFO is the head piece handed to game control.
//
// state  | meaning
// S_INIT | filling after reset; head not yet consumable
// S_RUN  | preview has been full once; head consumable whenever non-empty
module piece_bag_queue #(
  parameter int DEPTH    = 4,
  parameter int MAX_MISS = 15
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [2:0]           Rng_In,
  input  logic                 Pop,
  output logic [2:0]           Piece,
  output logic                 Piece_Valid,
  output logic [3*DEPTH-1:0]   Preview,
  output logic [3:0]           Count
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t             state_q, state_d;
  logic [3*DEPTH-1:0] fifo_q, fifo_d;
  logic [3:0]         count_q, count_d;
  logic [6:0]         mask_q, mask_d;
  logic [7:0]         miss_q, miss_d;

  logic       piece_valid;
  logic       pop_eff;
  logic       space;
  logic       code_ok;
  logic       force_fill;
  logic       push;
  logic [2:0] fill_code;
  logic [2:0] push_code;
  logic [3:0] tail_idx;
  logic [6:0] mask_set;
  logic [7:0] mask_ext;

  assign piece_valid = (state_q == S_RUN) && (count_q != 4'd0);

  // Lowest-numbered code not yet drawn from the current bag.
  always_comb begin
    fill_code = 3'd1;
    for (int k = 6; k >= 0; k--) begin
      if (!mask_q[k]) fill_code = 3'(k + 1);
    end
  end

  // Accept/force decision, FIFO shift and tail write, bag and miss bookkeeping.
  always_comb begin
    // Bit 0 stands in for code 0, which is never acceptable.
    mask_ext   = {mask_q, 1'b1};
    pop_eff    = Pop && piece_valid;
    space      = (count_q < 4'(DEPTH)) || pop_eff;
    code_ok    = !mask_ext[Rng_In];
    force_fill = space && (miss_q == 8'(MAX_MISS));
    push       = space && (force_fill || code_ok);
    push_code  = force_fill ? fill_code : Rng_In;
    tail_idx   = pop_eff ? (count_q - 4'd1) : count_q;

    fifo_d = pop_eff ? (fifo_q >> 3) : fifo_q;
    if (push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (tail_idx == 4'(i)) fifo_d[3*i +: 3] = push_code;
      end
    end

    count_d = count_q;
    if (push && !pop_eff)      count_d = count_q + 4'd1;
    else if (pop_eff && !push) count_d = count_q - 4'd1;

    mask_set = '0;
    for (int k = 0; k < 7; k++) begin
      if (push_code == 3'(k + 1)) mask_set[k] = 1'b1;
    end
    mask_d = mask_q;
    if (push) begin
      mask_d = mask_q | mask_set;
      // A completed bag starts over on the same edge as its last piece.
      if (mask_d == 7'h7F) mask_d = '0;
    end

    miss_d = miss_q;
    if (push)       miss_d = '0;
    else if (space) miss_d = miss_q + 8'd1;

    state_d = state_q;
    if ((state_q == S_INIT) && (count_d == 4'(DEPTH))) state_d = S_RUN;
  end

  // Register update with synchronous active-low reset taking priority.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= S_INIT;
      fifo_q  <= '0;
      count_q <= '0;
      mask_q  <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      fifo_q  <= fifo_d;
      count_q <= count_d;
      mask_q  <= mask_d;
      miss_q  <= miss_d;
    end
  end

  assign Piece       = fifo_q[2:0];
  assign Piece_Valid = piece_valid;
  assign Preview     = fifo_q;
  assign Count       = count_q;

endmodule
